// File: rtl/bht_pkg.sv
// Shared BHT types: 2-bit saturating counter encoding and its update rule.
package bht_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'd0;
  localparam bht_ctr_t WNT = 2'd1;
  localparam bht_ctr_t WT  = 2'd2;
  localparam bht_ctr_t ST  = 2'd3;

  function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
    if (taken)
      return (ctr == ST) ? ST : bht_ctr_t'(ctr + 2'd1);
    else
      return (ctr == SNT) ? SNT : bht_ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// In-order queue of pending BHT writes {idx, ctr} with a parallel search that
// returns the youngest queued value for a given index.
module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [IDX_W-1:0]           push_idx,
  input  bht_ctr_t                   push_ctr,
  input  logic                       pop,
  output logic [IDX_W-1:0]           head_idx,
  output bht_ctr_t                   head_ctr,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [IDX_W-1:0]           srch_idx,
  output logic                       srch_hit,
  output bht_ctr_t                   srch_ctr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx_mem [DEPTH];
  bht_ctr_t         ctr_mem [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;

  // Entry storage carries no reset: stale slots are masked by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[tail_reg] <= push_idx;
      ctr_mem[tail_reg] <= push_ctr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
    end
  end

  assign head_idx = idx_mem[head_reg];
  assign head_ctr = ctr_mem[head_reg];
  assign count    = count_reg;

  // Compare by age: slot gi is the gi-th oldest live entry.
  logic [DEPTH-1:0] age_hit;
  bht_ctr_t         age_ctr [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PTR_W-1:0] slot;
    assign slot        = head_reg + PTR_W'(gi);
    assign age_hit[gi] = (count_reg > (PTR_W+1)'(gi)) && (idx_mem[slot] == srch_idx);
    assign age_ctr[gi] = ctr_mem[slot];
  end

  always_comb begin
    srch_hit = 1'b0;
    srch_ctr = SNT;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_hit[i]) begin
        srch_hit = 1'b1;
        srch_ctr = age_ctr[i];
      end
    end
  end

endmodule

// File: rtl/bht_port_arbiter.sv
// Arbitrates the single BHT port between fetch lookups and queued EX updates,
// forwards queued values to lookups, and keeps write/stall statistics.
module bht_port_arbiter
  import bht_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lkp_valid,
  input  logic [IDX_W-1:0]  lkp_idx,
  output logic              lkp_ready,
  output logic              lkp_rvalid,
  output logic [1:0]        lkp_ctr,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic [1:0]        upd_ctr,
  output logic              upd_ready,
  output logic              bht_read,
  output logic              bht_write,
  output logic [IDX_W-1:0]  bht_idx,
  output logic [1:0]        bht_wdata,
  input  logic [1:0]        bht_rdata,
  output logic [31:0]       num_writes,
  output logic [31:0]       num_lkp_stall
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head_idx;
  bht_ctr_t         head_ctr;
  logic             srch_hit;
  bht_ctr_t         srch_ctr;
  logic             full;
  logic             drain;
  logic             push;

  logic             lkp_rvalid_reg;
  logic             fwd_hit_reg;
  bht_ctr_t         fwd_ctr_reg;
  logic [31:0]      num_writes_reg;
  logic [31:0]      num_lkp_stall_reg;

  assign full = (count == CNT_W'(DEPTH));
  assign push = upd_valid && upd_ready;

  bht_upd_fifo #(.IDX_W(IDX_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_idx (upd_idx),
    .push_ctr (sat_update(upd_ctr, upd_taken)),
    .pop      (drain),
    .head_idx (head_idx),
    .head_ctr (head_ctr),
    .count    (count),
    .srch_idx (lkp_idx),
    .srch_hit (srch_hit),
    .srch_ctr (srch_ctr)
  );

  // A full queue steals the port from fetch; otherwise lookups win and the
  // queue drains only on cycles fetch leaves idle.
  always_comb begin
    lkp_ready = !full;
    upd_ready = !full;
    drain     = full || (!lkp_valid && (count != '0));
    bht_read  = lkp_valid && !full;
    bht_write = drain;
    bht_idx   = '0;
    bht_wdata = SNT;
    if (drain) begin
      bht_idx   = head_idx;
      bht_wdata = head_ctr;
    end else if (bht_read) begin
      bht_idx   = lkp_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lkp_rvalid_reg    <= 1'b0;
      fwd_hit_reg       <= 1'b0;
      fwd_ctr_reg       <= SNT;
      num_writes_reg    <= '0;
      num_lkp_stall_reg <= '0;
    end else begin
      lkp_rvalid_reg <= bht_read;
      fwd_hit_reg    <= bht_read && srch_hit;
      fwd_ctr_reg    <= srch_ctr;
      if (drain)
        num_writes_reg <= num_writes_reg + 32'd1;
      if (lkp_valid && full)
        num_lkp_stall_reg <= num_lkp_stall_reg + 32'd1;
    end
  end

  // Queued values are newer than the array, so a forward hit overrides bht_rdata.
  assign lkp_rvalid    = lkp_rvalid_reg;
  assign lkp_ctr       = !lkp_rvalid_reg ? SNT : (fwd_hit_reg ? fwd_ctr_reg : bht_rdata);
  assign num_writes    = num_writes_reg;
  assign num_lkp_stall = num_lkp_stall_reg;

endmodule

// File: tb/tb_bht_port_arbiter.sv
// Randomized bench: lookups are checked against the architectural counter value
// implied by every accepted update; writes are checked against an in-order queue.
module tb_bht_port_arbiter;

  localparam int IDX_W = 6;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       ctr;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              lkp_valid = 1'b0;
  logic [IDX_W-1:0]  lkp_idx = '0;
  logic              lkp_ready;
  logic              lkp_rvalid;
  logic [1:0]        lkp_ctr;
  logic              upd_valid = 1'b0;
  logic [IDX_W-1:0]  upd_idx = '0;
  logic              upd_taken = 1'b0;
  logic [1:0]        upd_ctr = '0;
  logic              upd_ready;
  logic              bht_read;
  logic              bht_write;
  logic [IDX_W-1:0]  bht_idx;
  logic [1:0]        bht_wdata;
  logic [1:0]        bht_rdata = '0;
  logic [31:0]       num_writes;
  logic [31:0]       num_lkp_stall;

  bht_port_arbiter #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .lkp_valid     (lkp_valid),
    .lkp_idx       (lkp_idx),
    .lkp_ready     (lkp_ready),
    .lkp_rvalid    (lkp_rvalid),
    .lkp_ctr       (lkp_ctr),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .upd_ctr       (upd_ctr),
    .upd_ready     (upd_ready),
    .bht_read      (bht_read),
    .bht_write     (bht_write),
    .bht_idx       (bht_idx),
    .bht_wdata     (bht_wdata),
    .bht_rdata     (bht_rdata),
    .num_writes    (num_writes),
    .num_lkp_stall (num_lkp_stall)
  );

  always #5 clk = ~clk;

  // Behavioural single-ported counter array.
  logic [1:0] mem [2**IDX_W];
  initial for (int i = 0; i < 2**IDX_W; i++) mem[i] = 2'($urandom);
  always @(posedge clk) begin
    if (bht_write) mem[bht_idx] <= bht_wdata;
    if (bht_read)  bht_rdata    <= mem[bht_idx];
  end

  // Reference model state.
  logic [1:0]  arch [2**IDX_W];
  ent_t        q [$];
  logic [31:0] exp_writes = 0;
  logic [31:0] exp_stall  = 0;
  bit          pend_v     = 0;
  logic [1:0]  pend_ctr   = 0;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input bit t);
    int v;
    v = t ? int'(c) + 1 : int'(c) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic sync_model_after_reset();
    q.delete();
    for (int i = 0; i < 2**IDX_W; i++) arch[i] = mem[i];
    exp_writes = 0;
    exp_stall  = 0;
    pend_v     = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    upd_valid = 1'b1;
    upd_idx   = IDX_W'($urandom);
    lkp_valid = 1'b0;
    #1;
    chk("rst_upd_ready", upd_ready, 1);
    chk("rst_lkp_ready", lkp_ready, 1);
    chk("rst_write", bht_write, 0);
    chk("rst_rvalid", lkp_rvalid, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_write", bht_write, 0);
    chk("rst_hold_upd_ready", upd_ready, 1);
    rst       = 1'b0;
    upd_valid = 1'b0;
    sync_model_after_reset();
    #1;
    chk("rst_num_writes", num_writes, 0);
    chk("rst_num_stall", num_lkp_stall, 0);
    $display("reset applied, queue discarded");
  endtask

  task automatic cycle(input bit lv, input logic [IDX_W-1:0] li,
                       input bit uv, input logic [IDX_W-1:0] ui,
                       input bit ut, input logic [1:0] uc);
    bit full, drain, rd;
    ent_t e;
    @(negedge clk);
    chk("lkp_rvalid", lkp_rvalid, pend_v);
    if (pend_v) chk("lkp_ctr", lkp_ctr, pend_ctr);
    chk("num_writes", num_writes, exp_writes);
    chk("num_lkp_stall", num_lkp_stall, exp_stall);
    lkp_valid = lv; lkp_idx = li;
    upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_ctr = uc;
    #1;
    full  = (q.size() == DEPTH);
    drain = full || (!lv && q.size() != 0);
    rd    = lv && !full;
    chk("lkp_ready", lkp_ready, !full);
    chk("upd_ready", upd_ready, !full);
    chk("bht_write", bht_write, drain);
    chk("bht_read", bht_read, rd);
    if (drain) begin
      e = q.pop_front();
      chk("wr_idx", bht_idx, e.idx);
      chk("wr_data", bht_wdata, e.ctr);
      exp_writes++;
    end else if (rd) begin
      chk("rd_idx", bht_idx, li);
    end
    if (lv && full) exp_stall++;
    pend_v   = rd;
    pend_ctr = arch[li];
    if (uv && !full) begin
      e.idx = ui;
      e.ctr = sat(uc, ut);
      q.push_back(e);
      arch[ui] = e.ctr;
    end
    $display("cyc lkp=%0d/%0d upd=%0d/%0d/%0d/%0d wr=%0d rd=%0d q=%0d",
             lv, li, uv, ui, ut, uc, bht_write, bht_read, q.size());
  endtask

  initial begin
    do_reset();
    // Single update: idx 5, taken from 1 -> write 2.
    cycle(0, 0, 1, 5, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("single_wr_cnt", num_writes, 1);
    // Saturation at both ends.
    cycle(0, 0, 1, 3, 1, 3);
    cycle(0, 0, 1, 4, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Lookup every cycle while four updates fill the queue.
    for (int i = 0; i < 4; i++) cycle(1, 6'(40 + i), 1, 6'(20 + i), i[0], 2'(i));
    cycle(1, 50, 0, 0, 0, 0);
    cycle(1, 51, 0, 0, 0, 0);
    chk("fill_stalls", num_lkp_stall, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
    // Forwarding: idx 9 queued as 1 then 2, lookups keep the queue from draining.
    cycle(1, 30, 1, 9, 1, 0);
    cycle(1, 31, 1, 9, 1, 1);
    cycle(1, 9, 0, 0, 0, 0);
    cycle(1, 10, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
    // Same-cycle update and lookup to idx 7 with an empty queue.
    cycle(1, 7, 1, 7, 1, 2);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Reset with updates pending: none may be written afterwards.
    cycle(1, 1, 1, 11, 1, 1);
    cycle(1, 2, 1, 12, 0, 2);
    cycle(1, 3, 1, 13, 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
    chk("post_rst_writes", num_writes, 0);
    // Randomized traffic over a narrow index range to provoke forwarding.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 9) < 6, 6'($urandom_range(0, 11)),
            $urandom_range(0, 9) < 5, 6'($urandom_range(0, 11)),
            1'($urandom), 2'($urandom));
    end
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
